vend_change_ctrl: RTL and testbench
===================================

VEND_CHANGE_CTRL -- requirements
Module: vend_change_ctrl

Interface
REQ-001 SHALL have parameters: AMT_W, 7, change amount width in cents; CNT_W, 6, per-coin inventory counter width; INIT_25 / INIT_10 / INIT_5, 20, reset inventory per coin.
REQ-002 SHALL have ports: clk  in  1  clock (all state on posedge); rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: req_valid  in  1  change request; req_amount  in  AMT_W  change owed in cents; req_ready  out  1  high only in IDLE.
REQ-004 SHALL have ports: eject_valid  out  1  hopper command; eject  out  2  coin select (00 none, 01 5c, 10 10c, 11 25c); eject_ack  in  1  hopper done.
REQ-005 SHALL have ports: refill_valid  in  1; refill_coin  in  2  coin code, one coin added per cycle.
REQ-006 SHALL have ports: done  out  1  one-cycle pulse on full payout; err  out  1  one-cycle pulse on failure; err_amount  out  AMT_W  unpaid remainder, held until next accepted request; busy  out  1  not IDLE.
REQ-007 SHALL have ports: inv25 / inv10 / inv5  out  CNT_W  current coin inventories.

Function
REQ-008 SHALL implement FSM states IDLE, SELECT, EJECT, DONE, ERR.
REQ-009 IDLE: on req_valid&&req_ready, SHALL latch req_amount into remainder register rem and enter SELECT next cycle.
REQ-010 Amount not a multiple of 5 or above 95 SHALL go IDLE->ERR directly, no eject, err_amount=req_amount.
REQ-011 SELECT (one cycle): rem==0 -> DONE; else pick greedy the largest coin <= rem with nonzero inventory (25, then 10, then 5) -> EJECT; none fits -> ERR with err_amount=rem.
REQ-012 Greedy only SHALL be used; no backtracking (30c with no 5c and one 25c SHALL pay 25c then error with err_amount=5).
REQ-013 EJECT: eject_valid=1 with eject stable until the cycle eject_ack is sampled high; that cycle rem -= coin value, inventory of that coin -1, next state SELECT.
REQ-014 eject_ack outside EJECT SHALL be ignored; eject SHALL be 00 whenever eject_valid=0.
REQ-015 DONE and ERR SHALL each last exactly one cycle, pulse done/err, then return to IDLE.
REQ-016 Refill SHALL increment the selected counter, saturating at 2^CNT_W-1; refill_coin 00 SHALL be ignored; refill accepted in any state.
REQ-017 Refill and ack-decrement of the same coin in one cycle SHALL leave that counter unchanged.
REQ-018 rem arithmetic SHALL be AMT_W unsigned; underflow impossible by REQ-011.
REQ-019 Latency: request of 0 SHALL pulse done 2 cycles after acceptance; each coin adds 1 SELECT cycle plus ack wait.

Reset
REQ-020 rst_n low SHALL asynchronously force IDLE, rem=0, eject_valid=0, eject=00, done=0, err=0, err_amount=0, busy=0, inventories=INIT_*, including mid-EJECT.
REQ-021 After rst_n release, first request SHALL be accepted on the first clk edge.

Configuration
REQ-022 Macro VEND_CHANGE_INV_EN defined: inventory tracking per REQ-011/013/016/017.
REQ-023 Undefined: inventory treated infinite, counters removed, inv25/inv10/inv5 tied to all-ones, refill ignored, REQ-011 greedy ignores inventory.

Structure
REQ-024 Shared package vend_pkg SHALL hold coin code constants (COIN_NONE/5/10/25), coin value constants (5, 10, 25), FSM state typedef.
REQ-025 Sub-module vend_coin_pick (combinational greedy selector: rem + inventory nonzero flags -> coin code) is natural; inventory counters stay in top.

Verification
REQ-026 Reset, req 40, ack 2 cycles after each eject -> ejects 11 then 01... corrected: 11,10,01; done; inv25=19, inv10=19, inv5=19.
REQ-027 req 0 -> no eject, done pulse 2 cycles after acceptance.
REQ-028 req 7 -> no eject, err pulse, err_amount=7; req 100 -> err, err_amount=100.
REQ-029 (INV_EN) inv5=0, inv25=1, req 30 -> eject 11, then err, err_amount=5, inv25=0.
REQ-030 rst_n low during EJECT for 10c -> eject_valid drops immediately, IDLE, inventories back to INIT.
REQ-031 (INV_EN) refill 10c same cycle as ack for 10c -> inv10 unchanged; refill at max -> saturates.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared definitions for the change-dispensing controller: coin codes,
// coin values and the FSM state encoding.
package vend_pkg;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;
    localparam logic [1:0] COIN_25   = 2'b11;

    localparam int VAL_5      = 5;
    localparam int VAL_10     = 10;
    localparam int VAL_25     = 25;
    localparam int MAX_AMOUNT = 95;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        EJECT,
        DONE,
        ERR
    } state_t;

    function automatic int coin_value(input logic [1:0] code);
        case (code)
            COIN_5:  return VAL_5;
            COIN_10: return VAL_10;
            COIN_25: return VAL_25;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/vend_coin_pick.sv
// Combinational greedy coin selector: largest available coin not above rem.
// avail bit order: [2] 25c, [1] 10c, [0] 5c.
module vend_coin_pick
    import vend_pkg::*;
#(
    parameter int AMT_W = 7
) (
    input  logic [AMT_W-1:0] rem,
    input  logic [2:0]       avail,
    output logic [1:0]       coin
);

    always_comb begin
        coin = COIN_NONE;
        if (avail[2] && rem >= AMT_W'(VAL_25)) begin
            coin = COIN_25;
        end else if (avail[1] && rem >= AMT_W'(VAL_10)) begin
            coin = COIN_10;
        end else if (avail[0] && rem >= AMT_W'(VAL_5)) begin
            coin = COIN_5;
        end
    end

endmodule

// File: rtl/vend_change_ctrl.sv
// Change payout controller: greedy coin ejection with per-coin inventories.
// Define VEND_CHANGE_INV_EN to track inventories; otherwise supply is infinite.
//
// state  | meaning
// IDLE   | ready for a request
// SELECT | choose next coin, or finish / fail
// EJECT  | hopper command held until eject_ack
// DONE   | one-cycle payout-complete pulse
// ERR    | one-cycle failure pulse, err_amount holds unpaid remainder
module vend_change_ctrl
    import vend_pkg::*;
#(
    parameter int AMT_W   = 7,
    parameter int CNT_W   = 6,
    parameter int INIT_25 = 20,
    parameter int INIT_10 = 20,
    parameter int INIT_5  = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    input  logic [AMT_W-1:0] req_amount,
    output logic             req_ready,
    output logic             eject_valid,
    output logic [1:0]       eject,
    input  logic             eject_ack,
    input  logic             refill_valid,
    input  logic [1:0]       refill_coin,
    output logic             done,
    output logic             err,
    output logic [AMT_W-1:0] err_amount,
    output logic             busy,
    output logic [CNT_W-1:0] inv25,
    output logic [CNT_W-1:0] inv10,
    output logic [CNT_W-1:0] inv5
);

    state_t           state, state_nx;
    logic [AMT_W-1:0] rem, rem_nx, err_amt_nx;
    logic [1:0]       cur_coin, cur_coin_nx, pick;
    logic [2:0]       avail;
    logic             req_bad;

    assign req_bad = ((req_amount % AMT_W'(5)) != '0) || (req_amount > AMT_W'(MAX_AMOUNT));

    vend_coin_pick #(.AMT_W(AMT_W)) u_pick (
        .rem   (rem),
        .avail (avail),
        .coin  (pick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rem        <= '0;
            err_amount <= '0;
            cur_coin   <= COIN_NONE;
        end else begin
            state      <= state_nx;
            rem        <= rem_nx;
            err_amount <= err_amt_nx;
            cur_coin   <= cur_coin_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        rem_nx      = rem;
        err_amt_nx  = err_amount;
        cur_coin_nx = cur_coin;
        req_ready   = 1'b0;
        eject_valid = 1'b0;
        eject       = COIN_NONE;
        done        = 1'b0;
        err         = 1'b0;
        busy        = 1'b1;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    err_amt_nx = '0;
                    if (req_bad) begin
                        err_amt_nx = req_amount;
                        state_nx   = ERR;
                    end else begin
                        rem_nx   = req_amount;
                        state_nx = SELECT;
                    end
                end
            end
            SELECT: begin
                if (rem == '0) begin
                    state_nx = DONE;
                end else if (pick == COIN_NONE) begin
                    err_amt_nx = rem;
                    state_nx   = ERR;
                end else begin
                    cur_coin_nx = pick;
                    state_nx    = EJECT;
                end
            end
            EJECT: begin
                eject_valid = 1'b1;
                eject       = cur_coin;
                if (eject_ack) begin
                    rem_nx   = rem - AMT_W'(coin_value(cur_coin));
                    state_nx = SELECT;
                end
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            ERR: begin
                err      = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

`ifdef VEND_CHANGE_INV_EN
    logic ack_take;
    assign ack_take = (state == EJECT) && eject_ack;

    // Index i holds coin code i+1; a refill and an eject of the same coin cancel.
    for (genvar i = 0; i < 3; i++) begin : g_inv
        localparam logic [1:0] CODE   = 2'(i + 1);
        localparam int         INIT_V = (i == 0) ? INIT_5 : ((i == 1) ? INIT_10 : INIT_25);
        logic [CNT_W-1:0] cnt;
        logic             inc, dec;

        assign inc = refill_valid && (refill_coin == CODE);
        assign dec = ack_take && (cur_coin == CODE);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt <= CNT_W'(INIT_V);
            end else if (inc && !dec) begin
                if (cnt != '1) cnt <= cnt + 1'b1;
            end else if (dec && !inc) begin
                cnt <= cnt - 1'b1;
            end
        end

        assign avail[i] = (cnt != '0);
    end

    assign inv5  = g_inv[0].cnt;
    assign inv10 = g_inv[1].cnt;
    assign inv25 = g_inv[2].cnt;
`else
    localparam int unused_init = INIT_25 + INIT_10 + INIT_5;
    logic unused_refill;
    assign unused_refill = ^{refill_valid, refill_coin};

    assign avail = 3'b111;
    assign inv25 = '1;
    assign inv10 = '1;
    assign inv5  = '1;
`endif

endmodule

// File: tb/tb_vend_change_ctrl.sv
// Scoreboard bench for vend_change_ctrl: a coin-level payout model predicts
// ejects, terminal pulses and their cycle offsets; a monitor pops and compares.
module tb_vend_change_ctrl;
    import vend_pkg::*;

    localparam int AMT_W = 7;
    localparam int CNT_W = 6;
    localparam int INIT  = 20;
    localparam int CMAX  = 63;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             req_valid = 1'b0;
    logic [AMT_W-1:0] req_amount = '0;
    logic             req_ready;
    logic             eject_valid;
    logic [1:0]       eject;
    logic             eject_ack = 1'b0;
    logic             refill_valid = 1'b0;
    logic [1:0]       refill_coin = 2'b00;
    logic             done, err, busy;
    logic [AMT_W-1:0] err_amount;
    logic [CNT_W-1:0] inv25, inv10, inv5;

    vend_change_ctrl #(
        .AMT_W(AMT_W), .CNT_W(CNT_W), .INIT_25(INIT), .INIT_10(INIT), .INIT_5(INIT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_amount(req_amount), .req_ready(req_ready),
        .eject_valid(eject_valid), .eject(eject), .eject_ack(eject_ack),
        .refill_valid(refill_valid), .refill_coin(refill_coin),
        .done(done), .err(err), .err_amount(err_amount), .busy(busy),
        .inv25(inv25), .inv10(inv10), .inv5(inv5)
    );

    always #5 clk = ~clk;

    // kind: 0 eject, 1 done, 2 err; cyc is the offset from the request cycle
    typedef struct {
        int kind;
        int coin;
        int amt;
        int cyc;
    } ev_t;

    ev_t exp_q[$];
    int  vectors = 0;
    int  miscompares = 0;
    int  ncyc = 0;
    int  acc_n = 0;
    int  model_inv[3] = '{INIT, INIT, INIT};  // 5c, 10c, 25c
    int  cv[3] = '{5, 10, 25};
    int  ack_dly = 0;
    bit  ack_en = 1'b1;
    bit  ack_noise = 1'b0;
    bit  refill_on_ack = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit coin_ok(input int k);
`ifdef VEND_CHANGE_INV_EN
        return model_inv[k] > 0;
`else
        return 1'b1;
`endif
    endfunction

    function automatic void push_ev(input int kind, input int coin, input int amt, input int cyc);
        ev_t e;
        e.kind = kind; e.coin = coin; e.amt = amt; e.cyc = cyc;
        exp_q.push_back(e);
    endfunction

    // Payout model: greedy over coin values; EJECT lasts dly+1 cycles, SELECT one.
    function automatic void predict(input int amount, input int dly);
        int rem, t, c;
        if ((amount % 5) != 0 || amount > 95) begin
            push_ev(2, 0, amount, 1);
            return;
        end
        rem = amount;
        t = 1;
        while (rem > 0) begin
            c = -1;
            for (int k = 2; k >= 0; k--)
                if (c < 0 && cv[k] <= rem && coin_ok(k)) c = k;
            if (c < 0) begin
                push_ev(2, 0, rem, t + 1);
                return;
            end
            push_ev(0, c + 1, 0, t + 1);
            rem -= cv[c];
`ifdef VEND_CHANGE_INV_EN
            model_inv[c]--;
`endif
            t = t + 1 + dly + 1;
        end
        push_ev(1, 0, 0, t + 1);
    endfunction

    task automatic expect_ev(input int kind, input int coin, input int amt);
        ev_t e;
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_event: got kind=%0d coin=%0d amt=%0d, expected none", kind, coin, amt);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", kind, e.kind);
            if (kind == e.kind) begin
                if (kind == 0) chk("eject_coin", coin, e.coin);
                else chk("err_amount", amt, e.amt);
            end
            chk("event_latency", ncyc - acc_n, e.cyc);
        end
    endtask

    task automatic chk_inv(input string name);
`ifdef VEND_CHANGE_INV_EN
        chk({name, "_inv5"}, int'(inv5), model_inv[0]);
        chk({name, "_inv10"}, int'(inv10), model_inv[1]);
        chk({name, "_inv25"}, int'(inv25), model_inv[2]);
`else
        chk({name, "_inv5"}, int'(inv5), CMAX);
        chk({name, "_inv10"}, int'(inv10), CMAX);
        chk({name, "_inv25"}, int'(inv25), CMAX);
`endif
    endtask

    // Monitor
    initial begin
        bit prev_ev;
        prev_ev = 1'b0;
        forever begin
            @(negedge clk);
            ncyc++;
            if (!rst_n) begin
                prev_ev = 1'b0;
            end else begin
                if (req_valid && req_ready) acc_n = ncyc;
                if (!eject_valid) chk("eject_idle_code", int'(eject), 0);
                if (eject_valid && !prev_ev) expect_ev(0, int'(eject), 0);
                if (done) expect_ev(1, 0, int'(err_amount));
                if (err) expect_ev(2, 0, int'(err_amount));
                prev_ev = eject_valid;
            end
        end
    end

    // Hopper model: ack after ack_dly cycles in EJECT; optional stray acks otherwise
    initial begin
        int  wcnt;
        bit  ref_fired;
        wcnt = 0;
        ref_fired = 1'b0;
        forever begin
            @(negedge clk);
            eject_ack = 1'b0;
            if (ref_fired) begin
                refill_valid = 1'b0;
                refill_coin = 2'b00;
                ref_fired = 1'b0;
            end
            if (eject_valid && ack_en) begin
                if (wcnt == ack_dly) begin
                    eject_ack = 1'b1;
                    wcnt = 0;
                    if (refill_on_ack) begin
                        refill_valid = 1'b1;
                        refill_coin = COIN_10;
                        refill_on_ack = 1'b0;
                        ref_fired = 1'b1;
                    end
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
                if (ack_noise && !eject_valid) eject_ack = ($urandom_range(0, 3) == 0);
            end
        end
    end

    // Called at posedge+2; returns at posedge+2 with the DUT idle.
    task automatic do_req(input int amount, input int dly);
        int n;
        ack_dly = dly;
        predict(amount, dly);
        req_valid = 1'b1;
        req_amount = AMT_W'(amount);
        @(posedge clk); #2;
        req_valid = 1'b0;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 400) begin
            @(posedge clk); #2;
            n++;
        end
        if (n >= 400) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout amount=%0d: pending=%0d busy=%0d, expected idle", amount, exp_q.size(), busy);
            exp_q.delete();
        end
        chk_inv("after_req");
    endtask

    task automatic refill(input logic [1:0] code, input int n);
        for (int k = 0; k < n; k++) begin
            refill_valid = 1'b1;
            refill_coin = code;
`ifdef VEND_CHANGE_INV_EN
            if (code != 2'b00)
                model_inv[int'(code) - 1] = (model_inv[int'(code) - 1] < CMAX) ? model_inv[int'(code) - 1] + 1 : CMAX;
`endif
            @(posedge clk); #2;
        end
        refill_valid = 1'b0;
        refill_coin = 2'b00;
    endtask

    task automatic reset_checks(input string name);
        chk({name, "_busy"}, int'(busy), 0);
        chk({name, "_ready"}, int'(req_ready), 1);
        chk({name, "_eject_valid"}, int'(eject_valid), 0);
        chk({name, "_eject"}, int'(eject), 0);
        chk({name, "_done"}, int'(done), 0);
        chk({name, "_err"}, int'(err), 0);
        chk({name, "_err_amount"}, int'(err_amount), 0);
`ifdef VEND_CHANGE_INV_EN
        chk({name, "_inv5"}, int'(inv5), INIT);
        chk({name, "_inv10"}, int'(inv10), INIT);
        chk({name, "_inv25"}, int'(inv25), INIT);
`else
        chk({name, "_inv5"}, int'(inv5), CMAX);
        chk({name, "_inv10"}, int'(inv10), CMAX);
        chk({name, "_inv25"}, int'(inv25), CMAX);
`endif
    endtask

    initial begin
        int n;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset_checks("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;

        // 40c: 25, 10, 5 with ack two cycles into each eject
        do_req(40, 2);
        do_req(0, 0);
        do_req(7, 1);
        do_req(100, 1);
        do_req(95, 0);

        ack_noise = 1'b1;
        for (int i = 0; i < 60; i++) begin
            int amt, sel;
            sel = $urandom_range(0, 9);
            if (sel == 0) amt = $urandom_range(0, 127);
            else if (sel == 1) amt = 0;
            else amt = 5 * $urandom_range(1, 19);
            if ($urandom_range(0, 3) == 0) refill(2'($urandom_range(0, 3)), $urandom_range(1, 3));
            do_req(amt, $urandom_range(0, 3));
        end
        ack_noise = 1'b0;

        // Refill and ack of 10c in the same cycle cancel out
        refill(COIN_10, 2);
        do_req(10, 0);
        refill_on_ack = 1'b1;
`ifdef VEND_CHANGE_INV_EN
        model_inv[1] = model_inv[1] + 1;
`endif
        do_req(10, 1);
        refill_on_ack = 1'b0;

        refill(COIN_10, 70);
        chk("inv10_saturated", int'(inv10), CMAX);
        refill(COIN_NONE, 3);
        chk_inv("after_null_refill");

`ifdef VEND_CHANGE_INV_EN
        // Greedy without backtracking: 30c with one 25c and no 5c
        while (model_inv[0] > 0) do_req(5, 0);
        if (model_inv[2] == 0) refill(COIN_25, 1);
        while (model_inv[2] > 1) do_req(25, 0);
        do_req(30, 1);
        chk("inv25_after_30", int'(inv25), 0);
        chk("err_amount_held", int'(err_amount), 5);
`endif

        // Reset in the middle of a 10c eject
        refill(COIN_10, 2);
        ack_en = 1'b0;
        predict(10, 0);
        req_valid = 1'b1;
        req_amount = AMT_W'(10);
        @(posedge clk); #2;
        req_valid = 1'b0;
        n = 0;
        while (!eject_valid && n < 20) begin
            @(posedge clk); #2;
            n++;
        end
        chk("eject_seen_before_reset", int'(eject_valid), 1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        reset_checks("mid_eject_reset");
        exp_q.delete();
        model_inv = '{INIT, INIT, INIT};
        @(posedge clk); #1;
        rst_n = 1'b1;
        ack_en = 1'b1;
        #1;
        do_req(15, 1);
        do_req(65, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
